sort_sequencer: RTL and testbench
=================================

SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 Parameter SIZE, 4, number of lanes in the sort/unsort datapath being sequenced.
REQ-002 Parameter MIN_PHASE, SIZE+2, minimum cycles in a phase before its done input is honoured.
REQ-003 Parameter TIMEOUT, 4*SIZE+8, phase cycle count at which a missing done becomes an error; SHALL exceed MIN_PHASE.
REQ-004 Parameter COUNT_WIDTH, 16, width of frame_count.
REQ-005 Port clk, input, 1, sole clock; all logic on posedge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port in_valid / in_ready, input / output, 1 / 1, frame-available handshake from upstream.
REQ-008 Port sort_start, output, 1, one-cycle launch pulse to the sort stage.
REQ-009 Port sort_done, input, 1, sort stage completion level (may be stale-high from a prior frame).
REQ-010 Port unsort_start, output, 1, one-cycle launch pulse to the unsort stage (drives its start/reset edge input).
REQ-011 Port unsort_done, input, 1, unsort completion level (sticky; stale-high from a prior frame).
REQ-012 Port out_valid / out_ready, output / input, 1 / 1, result-available handshake to downstream.
REQ-013 Port err_clear, input, 1, clears the error state.
REQ-014 Port busy, output, 1, high whenever state != IDLE.
REQ-015 Port timeout_err, output, 1, sticky timeout flag; err_phase, output, 1, 0 = sort timed out, 1 = unsort timed out.
REQ-016 Port frame_count, output, COUNT_WIDTH, completed frames, wraps modulo 2^COUNT_WIDTH.
REQ-017 Port state_dbg, output, 3, encoded state: IDLE=0, SORT_RUN=1, UNSORT_RUN=2, OUTPUT=3, ERROR=4.

Function
REQ-018 FSM states SHALL be IDLE, SORT_RUN, UNSORT_RUN, OUTPUT, ERROR; state, phase counter and all registered outputs update on posedge clk only.
REQ-019 in_ready SHALL equal (state==IDLE) OR (state==OUTPUT AND out_ready), and SHALL be 0 while reset is high.
REQ-020 Accept: in_valid AND in_ready at an edge -> next state SORT_RUN, phase_cnt=0, sort_start=1 for exactly that first SORT_RUN cycle.
REQ-021 phase_cnt SHALL increment every cycle in SORT_RUN/UNSORT_RUN, saturating at TIMEOUT.
REQ-022 Qualified done: done input high AND phase_cnt >= MIN_PHASE; done high earlier SHALL be ignored (stale-done masking).
REQ-023 SORT_RUN with qualified sort_done -> UNSORT_RUN, phase_cnt=0, unsort_start=1 for exactly that first UNSORT_RUN cycle.
REQ-024 UNSORT_RUN with qualified unsort_done -> OUTPUT.
REQ-025 Phase with phase_cnt==TIMEOUT and no qualified done -> ERROR; timeout_err=1; err_phase set per REQ-015.
REQ-026 Qualified done and timeout in the same cycle: done wins, no error.
REQ-027 OUTPUT: out_valid=1, held stable until out_valid AND out_ready; on that edge frame_count += 1 and next state IDLE, or SORT_RUN (with sort_start pulse) if in_valid is also high the same cycle.
REQ-028 ERROR: in_ready=0, out_valid=0, no start pulses; err_clear=1 -> IDLE, timeout_err=0 next cycle; err_clear in any other state ignored.
REQ-029 Minimum latency accept -> out_valid SHALL be 2*(MIN_PHASE+1) cycles; sort_start and unsort_start SHALL never be high together.

Reset
REQ-030 reset high at an edge SHALL force IDLE, phase_cnt=0, frame_count=0, timeout_err=0, err_phase=0, sort_start=0, unsort_start=0, out_valid=0, from any state including mid-phase, with no start pulse reissued.
REQ-031 First cycle after reset deasserts: in_ready=1, busy=0, state_dbg=0.

Verification
REQ-032 SIZE=4 (MIN_PHASE=6, TIMEOUT=24); in_valid one cycle in IDLE, sort_done and unsort_done held high throughout -> sort_start pulse, unsort_start 7 cycles later, out_valid 14 cycles after accept, frame_count 0->1 on out_ready.
REQ-033 sort_done never asserted -> ERROR after 24 SORT_RUN cycles, timeout_err=1, err_phase=0; err_clear -> IDLE, timeout_err=0.
REQ-034 unsort_done asserts exactly at phase_cnt=24 -> OUTPUT, timeout_err stays 0.
REQ-035 OUTPUT with out_ready=0 for 5 cycles then out_ready=1 and in_valid=1 together -> out_valid stable 6 cycles, frame accepted same edge, sort_start next cycle, frame_count+1.
REQ-036 reset pulse at UNSORT_RUN phase_cnt=3 -> IDLE next cycle, frame_count=0, no unsort_start reissued; frame_count reaching 0xFFFF then one more frame -> 0x0000.

Source files
------------

// File: rtl/sort_sequencer.sv
// Launch/complete sequencer for a sort stage followed by an unsort stage.
// It masks stale done levels and flags a timeout when a phase overruns.
module sort_sequencer #(
  parameter int unsigned SIZE        = 4,
  parameter int unsigned MIN_PHASE   = SIZE + 2,
  parameter int unsigned TIMEOUT     = 4 * SIZE + 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   sort_start,
  input  logic                   sort_done,
  output logic                   unsort_start,
  input  logic                   unsort_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   err_clear,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   err_phase,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [2:0]             state_dbg
);

  localparam int unsigned PHASE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SORT_RUN   = 3'd1,
    UNSORT_RUN = 3'd2,
    OUTPUT     = 3'd3,
    ERROR      = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [PHASE_W-1:0]     phase_cnt, phase_cnt_next;
  logic                   sort_start_next, unsort_start_next, out_valid_next;
  logic                   timeout_err_next, err_phase_next;
  logic [COUNT_WIDTH-1:0] frame_count_next;
  logic                   sort_ok, unsort_ok, timed_out, accept;

  // Done levels are only trusted once the phase has run long enough to clear stale highs
  assign sort_ok   = sort_done   && (phase_cnt >= PHASE_W'(MIN_PHASE));
  assign unsort_ok = unsort_done && (phase_cnt >= PHASE_W'(MIN_PHASE));
  assign timed_out = (phase_cnt == PHASE_W'(TIMEOUT));

  assign in_ready  = !reset && ((state == IDLE) || ((state == OUTPUT) && out_ready));
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_next        = state;
    phase_cnt_next    = phase_cnt;
    sort_start_next   = 1'b0;
    unsort_start_next = 1'b0;
    timeout_err_next  = timeout_err;
    err_phase_next    = err_phase;
    frame_count_next  = frame_count;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next      = SORT_RUN;
          phase_cnt_next  = '0;
          sort_start_next = 1'b1;
        end
      end
      SORT_RUN: begin
        phase_cnt_next = timed_out ? phase_cnt : phase_cnt + PHASE_W'(1);
        if (sort_ok) begin
          state_next        = UNSORT_RUN;
          phase_cnt_next    = '0;
          unsort_start_next = 1'b1;
        end else if (timed_out) begin
          state_next       = ERROR;
          timeout_err_next = 1'b1;
          err_phase_next   = 1'b0;
        end
      end
      UNSORT_RUN: begin
        phase_cnt_next = timed_out ? phase_cnt : phase_cnt + PHASE_W'(1);
        if (unsort_ok) begin
          state_next = OUTPUT;
        end else if (timed_out) begin
          state_next       = ERROR;
          timeout_err_next = 1'b1;
          err_phase_next   = 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          frame_count_next = frame_count + COUNT_WIDTH'(1);
          if (in_valid) begin
            state_next      = SORT_RUN;
            phase_cnt_next  = '0;
            sort_start_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      ERROR: begin
        if (err_clear) begin
          state_next       = IDLE;
          timeout_err_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    out_valid_next = (state_next == OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      sort_start   <= 1'b0;
      unsort_start <= 1'b0;
      out_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      err_phase    <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_next;
      phase_cnt    <= phase_cnt_next;
      sort_start   <= sort_start_next;
      unsort_start <= unsort_start_next;
      out_valid    <= out_valid_next;
      timeout_err  <= timeout_err_next;
      err_phase    <= err_phase_next;
      frame_count  <= frame_count_next;
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: directed vector table, then random traffic against a timeline model.
module tb_sort_sequencer;

  localparam int unsigned MIN_PHASE = 6;
  localparam int unsigned TIMEOUT   = 24;
  localparam int unsigned CW        = 8;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, sort_start, sort_done, unsort_start, unsort_done;
  logic          out_valid, out_ready, err_clear, busy, timeout_err, err_phase;
  logic [CW-1:0] frame_count;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sort_sequencer #(.SIZE(4), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sort_start(sort_start), .sort_done(sort_done), .unsort_start(unsort_start),
    .unsort_done(unsort_done), .out_valid(out_valid), .out_ready(out_ready),
    .err_clear(err_clear), .busy(busy), .timeout_err(timeout_err), .err_phase(err_phase),
    .frame_count(frame_count), .state_dbg(state_dbg)
  );

  typedef struct {
    bit       rst, iv, sd, ud, ordy, ec;
    int       n;
    bit [2:0] st;
    bit       ir, ss, us, ov, te, ep;
    bit [7:0] fc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Timeline model: a phase is described by the cycle it began, not by a counter register
  int       m_state;
  longint   m_cyc, m_t0;
  bit       m_ss, m_us, m_te, m_ep;
  int       m_fc;

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_t0 = 0;
    m_ss = 0; m_us = 0; m_te = 0; m_ep = 0; m_fc = 0;
  endtask

  task automatic model_check();
    bit ir;
    ir = !reset && (m_state == 0 || (m_state == 3 && out_ready));
    check("state_dbg", 32'(state_dbg), 32'(m_state));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("in_ready", 32'(in_ready), 32'(ir));
    check("sort_start", 32'(sort_start), 32'(m_ss));
    check("unsort_start", 32'(unsort_start), 32'(m_us));
    check("out_valid", 32'(out_valid), 32'(m_state == 3));
    check("timeout_err", 32'(timeout_err), 32'(m_te));
    check("err_phase", 32'(err_phase), 32'(m_ep));
    check("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic model_edge();
    longint el;
    el   = m_cyc - m_t0;
    m_ss = 0; m_us = 0;
    m_cyc++;
    if (reset) begin
      m_state = 0; m_te = 0; m_ep = 0; m_fc = 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin m_state = 1; m_t0 = m_cyc; m_ss = 1; end
        1: if (sort_done && el >= MIN_PHASE) begin m_state = 2; m_t0 = m_cyc; m_us = 1; end
           else if (el >= TIMEOUT) begin m_state = 4; m_te = 1; m_ep = 0; end
        2: if (unsort_done && el >= MIN_PHASE) m_state = 3;
           else if (el >= TIMEOUT) begin m_state = 4; m_te = 1; m_ep = 1; end
        3: if (out_ready) begin
             m_fc = (m_fc + 1) % (1 << CW);
             if (in_valid) begin m_state = 1; m_t0 = m_cyc; m_ss = 1; end
             else m_state = 0;
           end
        4: if (err_clear) begin m_state = 0; m_te = 0; end
        default: m_state = 0;
      endcase
    end
  endtask

  vec_t vecs[$];

  task automatic add(input bit rst, iv, sd, ud, ordy, ec, input int n, input bit [2:0] st,
                     input bit ir, ss, us, ov, te, ep, input bit [7:0] fc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sd = sd; v.ud = ud; v.ordy = ordy; v.ec = ec; v.n = n;
    v.st = st; v.ir = ir; v.ss = ss; v.us = us; v.ov = ov; v.te = te; v.ep = ep; v.fc = fc;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1; in_valid = 0; sort_done = 0; unsort_done = 0; out_ready = 0; err_clear = 0;

    //   rst iv sd ud or ec  n | st ir ss us ov te ep fc
    add(1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1,  0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0,  1,  1, 0, 1, 0, 0, 0, 0, 0);  // accept with stale dones high
    add(0, 0, 1, 1, 0, 0,  1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  5,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1,  2, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1,  2, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  5,  2, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1,  3, 0, 0, 0, 1, 0, 0, 0);  // 14 cycles after accept
    add(0, 0, 1, 1, 0, 0,  3,  3, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0,  1,  0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 0,  1,  1, 0, 1, 0, 0, 0, 0, 1);  // sort timeout
    add(0, 0, 0, 0, 1, 0, 24,  1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  1,  4, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 1, 0,  2,  4, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1,  1,  0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0,  1,  1, 0, 1, 0, 0, 0, 0, 1);  // done arriving at the timeout count
    add(0, 0, 1, 0, 0, 0,  7,  2, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 24,  2, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0,  1,  3, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0,  5,  3, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0,  1,  1, 0, 1, 0, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0,  7,  2, 0, 0, 1, 0, 0, 0, 2);  // unsort timeout
    add(0, 0, 1, 0, 0, 0, 25,  4, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1,  1,  0, 1, 0, 0, 0, 0, 1, 2);
    add(0, 1, 1, 1, 0, 0,  1,  1, 0, 1, 0, 0, 0, 1, 2);  // reset mid-unsort
    add(0, 0, 1, 1, 0, 0,  7,  2, 0, 0, 1, 0, 0, 1, 2);
    add(0, 0, 1, 1, 0, 1,  3,  2, 0, 0, 0, 0, 0, 1, 2);
    add(1, 0, 1, 1, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1,  0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; in_valid = vecs[i].iv; sort_done = vecs[i].sd;
      unsort_done = vecs[i].ud; out_ready = vecs[i].ordy; err_clear = vecs[i].ec;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      check($sformatf("v%0d.state", i), 32'(state_dbg), 32'(vecs[i].st));
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].st != 0));
      check($sformatf("v%0d.sort_start", i), 32'(sort_start), 32'(vecs[i].ss));
      check($sformatf("v%0d.unsort_start", i), 32'(unsort_start), 32'(vecs[i].us));
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d.timeout_err", i), 32'(timeout_err), 32'(vecs[i].te));
      check($sformatf("v%0d.err_phase", i), 32'(err_phase), 32'(vecs[i].ep));
      check($sformatf("v%0d.frame_count", i), 32'(frame_count), 32'(vecs[i].fc));
    end

    // Align model and DUT on a reset edge before random traffic
    @(negedge clk);
    reset = 1; in_valid = 0; out_ready = 0; err_clear = 0;
    @(posedge clk);
    model_reset();

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 299) == 0);
      in_valid    = $urandom_range(0, 1) == 1;
      sort_done   = ($urandom_range(0, 7) == 0);
      unsort_done = ($urandom_range(0, 7) == 0);
      out_ready   = $urandom_range(0, 1) == 1;
      err_clear   = ($urandom_range(0, 3) == 0);
      #1;
      model_check();
      model_edge();
      @(posedge clk);
    end

    // Back-to-back frames so frame_count wraps through all-ones
    for (int c = 0; c < 3950; c++) begin
      @(negedge clk);
      reset = 0; in_valid = 1; sort_done = 1; unsort_done = 1; out_ready = 1; err_clear = 1;
      #1;
      model_check();
      model_edge();
      @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
